// File: rtl/prime_seg_display_pkg.sv
// Shared constants for the prime display: digit geometry, segment patterns
// and the conversion FSM state encoding.
package prime_seg_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 24;
  localparam int BIN_W      = 20;
  localparam int SHIFT_W    = BCD_W + BIN_W;
  localparam int MAX_VALUE  = 999999;

  // Segment patterns are active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the pins
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  function automatic logic [7:0] digitPattern(input logic [3:0] digit);
    case (digit)
      4'd0:    digitPattern = 8'h3F;
      4'd1:    digitPattern = 8'h06;
      4'd2:    digitPattern = 8'h5B;
      4'd3:    digitPattern = 8'h4F;
      4'd4:    digitPattern = 8'h66;
      4'd5:    digitPattern = 8'h6D;
      4'd6:    digitPattern = 8'h7D;
      4'd7:    digitPattern = 8'h07;
      4'd8:    digitPattern = 8'h7F;
      4'd9:    digitPattern = 8'h6F;
      default: digitPattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/prime_seg_display_bin2bcd.sv
// Sequential double-dabble: 20-bit binary to six BCD digits in 22 clocks
// (LOAD, twenty SHIFT cycles, COMMIT).
module bin2bcd_seq
  import prime_seg_display_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  logic [1:0]         r_state;
  logic [SHIFT_W-1:0] r_shift;
  logic [4:0]         r_count;
  logic [SHIFT_W-1:0] w_adjusted;

  always_comb begin
    w_adjusted = r_shift;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd5)
        w_adjusted[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (start) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_shift <= {{BCD_W{1'b0}}, bin};
          r_count <= 5'(BIN_W - 1);
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_shift <= {w_adjusted[SHIFT_W-2:0], 1'b0};
          if (r_count == 5'd0) r_state <= ST_COMMIT;
          else                 r_count <= r_count - 5'd1;
        end
        ST_COMMIT:
          r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  assign done = (r_state == ST_COMMIT);
  assign busy = (r_state != ST_IDLE);
  assign bcd  = r_shift[SHIFT_W-1:BIN_W];

endmodule

// File: rtl/prime_seg_display.sv
// Samples the sieve's prime on each timer edge, converts it to BCD and scans it
// onto a six-digit multiplexed 7-segment display.
module prime_seg_display
  import prime_seg_display_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             timer,
  input  logic [BIN_W-1:0] prime_num,
  output logic [5:0]       an,
  output logic [7:0]       seg,
  output logic             busy,
  output logic             overflow
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [2:0]       r_timerSync;
  logic             r_first;
  logic             r_pending;
  logic [BIN_W-1:0] r_binQ;
  logic [BCD_W-1:0] r_digits;
  logic             r_overflow;
  logic [DIV_W-1:0] r_scanDiv;
  logic [2:0]       r_scanIdx;
  logic [5:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_req;
  logic             w_start;
  logic             w_done;
  logic             w_busy;
  logic [BCD_W-1:0] w_bcd;
  logic [7:0]       w_curPat;
  logic [5:0]       w_anOneHot;

  // r_first forces one capture right after reset so the display tracks the sieve's reset value
  assign w_req   = (r_timerSync[1] & ~r_timerSync[2]) | r_first;
  assign w_start = r_pending & ~w_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timerSync <= '0;
      r_first     <= 1'b1;
      r_pending   <= 1'b0;
      r_binQ      <= '0;
      r_digits    <= 24'h000002;
      r_overflow  <= 1'b0;
    end else begin
      r_timerSync <= {r_timerSync[1:0], timer};
      r_first     <= 1'b0;
      if (w_req)        r_pending <= 1'b1;
      else if (w_start) r_pending <= 1'b0;
      if (w_start) r_binQ <= prime_num;
      if (w_done) begin
        r_digits   <= w_bcd;
        r_overflow <= (r_binQ > BIN_W'(MAX_VALUE));
      end
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rstn  (rstn),
    .start (w_start),
    .bin   (r_binQ),
    .done  (w_done),
    .bcd   (w_bcd),
    .busy  (w_busy)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scanDiv <= '0;
      r_scanIdx <= '0;
    end else if (r_scanDiv == DIV_LAST) begin
      r_scanDiv <= '0;
      r_scanIdx <= (r_scanIdx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_scanIdx + 3'd1;
    end else begin
      r_scanDiv <= r_scanDiv + 1'b1;
    end
  end

  // Walk from the top digit down; zeros stay blank until the first nonzero digit
  always_comb begin
    logic       leading;
    logic [7:0] pat;
    leading  = BLANK_LZ;
    pat      = SEG_BLANK;
    w_curPat = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      pat = digitPattern(r_digits[4*i +: 4]);
      if (leading && (i > 0) && (r_digits[4*i +: 4] == 4'd0)) pat = SEG_BLANK;
      else                                                     leading = 1'b0;
      if (r_overflow) pat = SEG_DASH;
      if (r_scanIdx == 3'(i)) w_curPat = pat;
    end
  end

  assign w_anOneHot = 6'b000001 << r_scanIdx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an  <= ACTIVE_LOW ? 6'h3F : 6'h00;
      r_seg <= ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      r_an  <= ACTIVE_LOW ? ~w_anOneHot : w_anOneHot;
      r_seg <= ACTIVE_LOW ? ~w_curPat : w_curPat;
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign busy     = w_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_prime_seg_display.sv
// Directed bench for prime_seg_display with a short scan period; expected
// segments come from an arithmetic decimal model.
module tb_prime_seg_display;

  localparam int SCAN_DIV = 4;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b1;
  logic        timer     = 1'b0;
  logic [19:0] prime_num = 20'd2;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] obsSeg   [6];
  logic [7:0] patTable [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  prime_seg_display #(
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_LZ   (1'b1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .timer     (timer),
    .prime_num (prime_num),
    .an        (an),
    .seg       (seg),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected active-low segment byte for digit idx of a displayed value
  function automatic logic [7:0] expSeg(input int value, input int idx);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (value > 999999)            return ~8'h40;
    if ((idx > 0) && (value < p))  return 8'hFF;
    return ~patTable[(value / p) % 10];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] value);
    @(negedge clk);
    prime_num = value;
    timer     = 1'b1;
    repeat (2) @(negedge clk);
    timer     = 1'b0;
  endtask

  task automatic waitConversion(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_busyRise"}, 32'(busy), 32'd1);
    n = 0;
    while ((busy !== 1'b0) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_busyFall"}, 32'(busy), 32'd0);
  endtask

  task automatic readDisplay(input int value, input string tag);
    int         prevIdx;
    int         idx;
    int         runLen;
    int         scanErr;
    int         hotErr;
    bit         firstRun;
    logic [5:0] act;
    prevIdx  = -1;
    idx      = 0;
    runLen   = 0;
    scanErr  = 0;
    hotErr   = 0;
    firstRun = 1'b1;
    for (int k = 0; k < 6; k++) obsSeg[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 12 * SCAN_DIV; c++) begin
      @(negedge clk);
      act = ~an;
      if ($countones(act) != 1) begin
        hotErr++;
      end else begin
        for (int k = 0; k < 6; k++) if (act[k]) idx = k;
        obsSeg[idx] = seg;
        if (idx == prevIdx) begin
          runLen++;
        end else begin
          if (prevIdx >= 0) begin
            if (idx != (prevIdx + 1) % 6) scanErr++;
            if (!firstRun && (runLen != SCAN_DIV)) scanErr++;
            firstRun = 1'b0;
          end
          prevIdx = idx;
          runLen  = 1;
        end
      end
    end
    checkOutput({tag, "_onehot"}, 32'(hotErr), 32'd0);
    checkOutput({tag, "_scan"}, 32'(scanErr), 32'd0);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("%s_d%0d", tag, k), 32'(obsSeg[k]), 32'(expSeg(value, k)));
  endtask

  initial begin
    int         commits;
    int         sinceFall;
    int         n;
    bit         prevBusy;
    bit         gotUnit;
    logic [7:0] unitSeg;

    // Reset state and the forced capture after release
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'h3F);
    checkOutput("rst_seg", 32'(seg), 32'hFF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    waitConversion("t1");
    readDisplay(2, "t1");
    checkOutput("t1_ovf", 32'(overflow), 32'd0);

    applyStimulus(20'd999983);
    waitConversion("t2");
    readDisplay(999983, "t2");
    checkOutput("t2_ovf", 32'(overflow), 32'd0);

    applyStimulus(20'hFFFFF);
    waitConversion("t3");
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    readDisplay(1048575, "t3");

    applyStimulus(20'd104729);
    waitConversion("t5");
    readDisplay(104729, "t5");
    checkOutput("t5_ovf", 32'(overflow), 32'd0);

    applyStimulus(20'd100);
    waitConversion("tlz");
    readDisplay(100, "tlz");

    // Second timer pulse lands during the first conversion
    applyStimulus(20'd7);
    repeat (2) @(negedge clk);
    applyStimulus(20'd11);
    commits   = 0;
    sinceFall = -1;
    gotUnit   = 1'b0;
    unitSeg   = 8'h00;
    prevBusy  = busy;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (prevBusy && !busy) begin
        commits++;
        if (commits == 1) sinceFall = 0;
      end else if ((commits == 1) && (sinceFall >= 0)) begin
        sinceFall++;
      end
      if ((commits == 1) && (sinceFall >= 1) && !gotUnit && (an == 6'h3E)) begin
        unitSeg = seg;
        gotUnit = 1'b1;
      end
      prevBusy = busy;
    end
    checkOutput("t4_commits", 32'(commits), 32'd2);
    checkOutput("t4_first", 32'(unitSeg), 32'hF8);
    readDisplay(11, "t4");

    // Reset asserted in the middle of a conversion
    applyStimulus(20'd50);
    n = 0;
    while ((busy !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_busyRise", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_an", 32'(an), 32'h3F);
    checkOutput("t6_seg", 32'(seg), 32'hFF);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_ovf", 32'(overflow), 32'd0);
    prime_num = 20'd2;
    @(negedge clk);
    rstn = 1'b1;
    waitConversion("t6");
    readDisplay(2, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
